// File: rtl/sap1_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_datapath
//  Description : Register-transfer datapath of the SAP-1 computer. It applies
//                the controller's registered 12-bit control word each cycle.
//                It contains PC, MAR, a 16x8 RAM, IR, A, B, the
//                adder/subtractor, carry/zero flags, a sticky halt latch and
//                a sticky bus-conflict flag. A loader port writes the RAM
//                directly.
//  Ports       :
//      clk_i           sole clock, rising-edge
//      rst_ni          asynchronous active-low reset
//      ctrl_i[11:0]    control word: [11] HLT, [10] PC_INC, [9] PC_EN,
//                      [8] MEM_LOAD, [7] MEM_EN, [6] IR_LOAD, [5] IR_EN,
//                      [4] A_LOAD, [3] A_EN, [2] B_LOAD, [1] ADDER_SUB,
//                      [0] ADDER_EN
//      prog_we_i       RAM write strobe from the program loader
//      prog_addr_i     RAM write address
//      prog_data_i     RAM write data
//      opcode_o        IR[7:4], returned to the controller
//      bus_o           current (combinational) bus value
//      a_out_o         A register
//      pc_out_o        program counter
//      carry_o         carry flag
//      zero_o          zero flag
//      halted_o        sticky halt latch
//      bus_conflict_o  sticky multi-driver error flag
//  Revision    : 1.0  initial release
// ============================================================================
module sap1_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [11:0]       ctrl_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic [3:0]        opcode_o,
    output logic [DATA_W-1:0] bus_o,
    output logic [DATA_W-1:0] a_out_o,
    output logic [ADDR_W-1:0] pc_out_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic              halted_o,
    output logic              bus_conflict_o
);

    // Control word bit positions
    localparam int c_HLT       = 11;
    localparam int c_PC_INC    = 10;
    localparam int c_PC_EN     = 9;
    localparam int c_MEM_LOAD  = 8;
    localparam int c_MEM_EN    = 7;
    localparam int c_IR_LOAD   = 6;
    localparam int c_IR_EN     = 5;
    localparam int c_A_LOAD    = 4;
    localparam int c_A_EN      = 3;
    localparam int c_B_LOAD    = 2;
    localparam int c_ADDER_SUB = 1;
    localparam int c_ADDER_EN  = 0;

    localparam int c_DEPTH = 2 ** ADDR_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] a_q,   a_d;
    logic [DATA_W-1:0] b_q,   b_d;
    logic              carry_q,    carry_d;
    logic              zero_q,     zero_d;
    logic              halted_q,   halted_d;
    logic              conflict_q, conflict_d;

    logic [DATA_W-1:0] mem_q [c_DEPTH];

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_mem_rd;
    logic [DATA_W-1:0] w_b_op;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_alu;
    logic              w_cout;
    logic [DATA_W-1:0] w_bus;
    logic [4:0]        w_drv;
    logic              w_multi;
    logic              w_run;

    // Asynchronous read at MAR; a same-edge loader write is seen next cycle.
    assign w_mem_rd = mem_q[mar_q];

    // Subtraction is A + ~B + 1; the carry out of that sum is the
    // no-borrow indication (set iff A >= B unsigned).
    assign w_b_op = b_q ^ {DATA_W{ctrl_i[c_ADDER_SUB]}};
    assign w_sum  = {1'b0, a_q} + {1'b0, w_b_op}
                  + {{DATA_W{1'b0}}, ctrl_i[c_ADDER_SUB]};
    assign w_alu  = w_sum[DATA_W-1:0];
    assign w_cout = w_sum[DATA_W];

    // Enabled bus drivers, highest priority in the MSB.
    assign w_drv = {ctrl_i[c_ADDER_EN], ctrl_i[c_A_EN], ctrl_i[c_MEM_EN],
                    ctrl_i[c_IR_EN], ctrl_i[c_PC_EN]};

    // More than one bit set: clearing the lowest set bit leaves a residue.
    assign w_multi = |(w_drv & (w_drv - 5'd1));

    // Priority mux: ADDER > A > MEM > IR > PC, zero when undriven.
    always_comb begin
        w_bus = {DATA_W{1'b0}};
        if (ctrl_i[c_ADDER_EN]) begin
            w_bus = w_alu;
        end else if (ctrl_i[c_A_EN]) begin
            w_bus = a_q;
        end else if (ctrl_i[c_MEM_EN]) begin
            w_bus = w_mem_rd;
        end else if (ctrl_i[c_IR_EN]) begin
            w_bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
        end else if (ctrl_i[c_PC_EN]) begin
            w_bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        end
    end

    // Once the halt latch is set, every control-driven update is frozen.
    assign w_run = ~halted_q;

    // ------------------------------------------------------------------
    // Next-state logic; every load samples the pre-edge bus so A_LOAD
    // together with A_EN/ADDER_EN has no loop through the register.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        mar_d      = mar_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        halted_d   = halted_q | ctrl_i[c_HLT];
        conflict_d = conflict_q;

        if (w_run) begin
            if (ctrl_i[c_PC_INC]) begin
                pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (ctrl_i[c_MEM_LOAD]) begin
                mar_d = w_bus[ADDR_W-1:0];
            end
            if (ctrl_i[c_IR_LOAD]) begin
                ir_d = w_bus;
            end
            if (ctrl_i[c_A_LOAD]) begin
                a_d = w_bus;
            end
            if (ctrl_i[c_B_LOAD]) begin
                b_d = w_bus;
            end
            // Flags track only an ALU result that is written back to A.
            if (ctrl_i[c_ADDER_EN] && ctrl_i[c_A_LOAD]) begin
                carry_d = w_cout;
                zero_d  = (w_alu == {DATA_W{1'b0}});
            end
            if (w_multi) begin
                conflict_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= '0;
            mar_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            halted_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            halted_q   <= halted_d;
            conflict_q <= conflict_d;
        end
    end

    // RAM has no reset so a loaded program survives a reset pulse, and the
    // loader may write at any time, including while halted or in reset.
    always_ff @(posedge clk_i) begin
        if (prog_we_i) begin
            mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign opcode_o       = ir_q[DATA_W-1:DATA_W-4];
    assign bus_o          = w_bus;
    assign a_out_o        = a_q;
    assign pc_out_o       = pc_q;
    assign carry_o        = carry_q;
    assign zero_o         = zero_q;
    assign halted_o       = halted_q;
    assign bus_conflict_o = conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_sap1_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap1_datapath
//  Description : Self-checking bench for sap1_datapath. A behavioural model
//                of the SAP-1 datapath is advanced alongside the DUT using
//                randomized and directed control words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sap1_datapath;

    localparam logic [11:0] HLT      = 12'h800;
    localparam logic [11:0] PC_INC   = 12'h400;
    localparam logic [11:0] PC_EN    = 12'h200;
    localparam logic [11:0] MEM_LOAD = 12'h100;
    localparam logic [11:0] MEM_EN   = 12'h080;
    localparam logic [11:0] IR_LOAD  = 12'h040;
    localparam logic [11:0] IR_EN    = 12'h020;
    localparam logic [11:0] A_LOAD   = 12'h010;
    localparam logic [11:0] A_EN     = 12'h008;
    localparam logic [11:0] B_LOAD   = 12'h004;
    localparam logic [11:0] SUB      = 12'h002;
    localparam logic [11:0] ADDER_EN = 12'h001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ctrl;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [7:0]  bus;
    logic [7:0]  a_out;
    logic [3:0]  pc_out;
    logic        carry, zero, halted, bus_conflict;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b;
    logic       m_c, m_z, m_halt, m_conf;
    logic [7:0] m_ram [16];

    sap1_datapath dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ctrl_i         (ctrl),
        .prog_we_i      (prog_we),
        .prog_addr_i    (prog_addr),
        .prog_data_i    (prog_data),
        .opcode_o       (opcode),
        .bus_o          (bus),
        .a_out_o        (a_out),
        .pc_out_o       (pc_out),
        .carry_o        (carry),
        .zero_o         (zero),
        .halted_o       (halted),
        .bus_conflict_o (bus_conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus value implied by the enabled drivers; later lines win, giving
    // ADDER > A > MEM > IR > PC.
    function automatic logic [7:0] model_bus(input logic [11:0] c);
        logic [7:0] v;
        int s;
        v = 8'h00;
        if (c[9]) v = {4'h0, m_pc};
        if (c[5]) v = {4'h0, m_ir[3:0]};
        if (c[7]) v = m_ram[m_mar];
        if (c[3]) v = m_a;
        if (c[0]) begin
            if (c[1]) s = int'(m_a) - int'(m_b);
            else      s = int'(m_a) + int'(m_b);
            v = s[7:0];
        end
        return v;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
        m_c = 0; m_z = 0; m_halt = 0; m_conf = 0;
    endtask

    task automatic model_edge(input logic [11:0] c, input logic we,
                              input logic [3:0] pa, input logic [7:0] pd,
                              input logic [7:0] bv);
        int n;
        if (!m_halt) begin
            n = int'(c[9]) + int'(c[7]) + int'(c[5]) + int'(c[3]) + int'(c[0]);
            if (c[0] && c[4]) begin
                if (c[1]) m_c = (m_a >= m_b);
                else      m_c = (int'(m_a) + int'(m_b)) > 255;
                m_z = (bv == 8'h00);
            end
            if (c[8])  m_mar = bv[3:0];
            if (c[6])  m_ir  = bv;
            if (c[4])  m_a   = bv;
            if (c[2])  m_b   = bv;
            if (c[10]) m_pc  = 4'((int'(m_pc) + 1) % 16);
            if (n > 1) m_conf = 1'b1;
            if (c[11]) m_halt = 1'b1;
        end
        if (we) m_ram[pa] = pd;
    endtask

    task automatic check_state();
        check("opcode",   {28'h0, opcode}, {28'h0, m_ir[7:4]});
        check("a_out",    {24'h0, a_out},  {24'h0, m_a});
        check("pc_out",   {28'h0, pc_out}, {28'h0, m_pc});
        check("carry",    {31'h0, carry},  {31'h0, m_c});
        check("zero",     {31'h0, zero},   {31'h0, m_z});
        check("halted",   {31'h0, halted}, {31'h0, m_halt});
        check("conflict", {31'h0, bus_conflict}, {31'h0, m_conf});
        check("bus_post", {24'h0, bus},    {24'h0, model_bus(ctrl)});
    endtask

    // One clock cycle: drive inputs, check the combinational bus, clock,
    // advance the model and compare all outputs.
    task automatic step(input logic [11:0] c, input logic we,
                        input logic [3:0] pa, input logic [7:0] pd);
        logic [7:0] eb;
        ctrl = c; prog_we = we; prog_addr = pa; prog_data = pd;
        #1;
        eb = model_bus(c);
        check("bus_pre", {24'h0, bus}, {24'h0, eb});
        @(posedge clk);
        model_edge(c, we, pa, pd, eb);
        #1;
        prog_we = 1'b0;
        check_state();
    endtask

    task automatic stepc(input logic [11:0] c);
        step(c, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic load_a(input logic [7:0] v);
        step(12'h000, 1'b1, m_mar, v);
        stepc(MEM_EN | A_LOAD);
    endtask

    task automatic load_b(input logic [7:0] v);
        step(12'h000, 1'b1, m_mar, v);
        stepc(MEM_EN | B_LOAD);
    endtask

    task automatic assert_reset();
        ctrl = 12'h000; prog_we = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
    endtask

    task automatic write_in_reset(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk);
        m_ram[a] = d;
        #1;
        prog_we = 1'b0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [11:0] rand_ctrl();
        logic [11:0] c;
        c = 12'($urandom) & 12'h556;
        case ($urandom_range(0, 7))
            1: c |= PC_EN;
            2: c |= MEM_EN;
            3: c |= IR_EN;
            4: c |= A_EN;
            5: c |= ADDER_EN;
            6, 7: c |= 12'($urandom) & 12'h2A9;
            default: ;
        endcase
        return c;
    endfunction

    initial begin
        logic [11:0] rc;
        ctrl = 12'h000; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;

        // Power-on reset, initialise every RAM word while in reset.
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        for (int i = 0; i < 16; i++) write_in_reset(4'(i), 8'($urandom));
        release_reset();

        // Randomized traffic without HLT.
        for (int i = 0; i < 300; i++) begin
            step(rand_ctrl(), ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom));
        end
        // Halt with random companions, then prove the state freezes.
        rc = rand_ctrl() | HLT;
        stepc(rc);
        for (int i = 0; i < 12; i++) begin
            step(rand_ctrl(), ($urandom_range(0, 1) == 0), 4'($urandom), 8'($urandom));
        end

        // Mid-run reset with A=0x55 and PC=7.
        assert_reset();
        release_reset();
        for (int i = 0; i < 7; i++) stepc(PC_INC);
        load_a(8'h55);
        check("pre_rst_a",  {24'h0, a_out},  32'h55);
        check("pre_rst_pc", {28'h0, pc_out}, 32'h7);
        assert_reset();
        check("rst_a",  {24'h0, a_out},  32'h0);
        check("rst_pc", {28'h0, pc_out}, 32'h0);
        write_in_reset(4'h0, 8'h09);
        write_in_reset(4'h1, 8'h1A);
        write_in_reset(4'h2, 8'h2B);
        write_in_reset(4'h3, 8'hF0);
        write_in_reset(4'h9, 8'h05);
        write_in_reset(4'hA, 8'h03);
        write_in_reset(4'hB, 8'h07);
        release_reset();

        // Run the program as the controller would sequence it.
        for (int g = 0; g < 12 && !m_halt; g++) begin
            stepc(PC_EN | MEM_LOAD);
            stepc(PC_INC);
            stepc(MEM_EN | IR_LOAD);
            case (m_ir[7:4])
                4'h0: begin
                    stepc(IR_EN | MEM_LOAD);
                    stepc(MEM_EN | A_LOAD);
                end
                4'h1: begin
                    stepc(IR_EN | MEM_LOAD);
                    stepc(MEM_EN | B_LOAD);
                    stepc(ADDER_EN | A_LOAD);
                end
                4'h2: begin
                    stepc(IR_EN | MEM_LOAD);
                    stepc(MEM_EN | B_LOAD);
                    stepc(ADDER_EN | SUB | A_LOAD);
                end
                4'hF: stepc(HLT);
                default: stepc(12'h000);
            endcase
        end
        check("prog_halted", {31'h0, halted}, 32'h1);
        check("prog_a",      {24'h0, a_out},  32'h01);
        check("prog_carry",  {31'h0, carry},  32'h1);
        check("prog_zero",   {31'h0, zero},   32'h0);
        check("prog_pc",     {28'h0, pc_out}, 32'h4);
        for (int i = 0; i < 6; i++) stepc(rand_ctrl());
        check("post_halt_a",  {24'h0, a_out},  32'h01);
        check("post_halt_pc", {28'h0, pc_out}, 32'h4);

        // Add overflow and subtract underflow.
        assert_reset();
        release_reset();
        load_a(8'hFF);
        load_b(8'h01);
        stepc(ADDER_EN | A_LOAD);
        check("add_a", {24'h0, a_out}, 32'h00);
        check("add_c", {31'h0, carry}, 32'h1);
        check("add_z", {31'h0, zero},  32'h1);
        load_a(8'h03);
        load_b(8'h05);
        stepc(ADDER_EN | SUB | A_LOAD);
        check("sub_a", {24'h0, a_out}, 32'hFE);
        check("sub_c", {31'h0, carry}, 32'h0);
        check("sub_z", {31'h0, zero},  32'h0);

        // PC wrap and MAR following it.
        while (m_pc != 4'hF) stepc(PC_INC);
        stepc(PC_INC);
        check("pc_wrap", {28'h0, pc_out}, 32'h0);
        stepc(PC_EN | MEM_LOAD);
        stepc(MEM_EN);
        check("mar_zero_rd", {24'h0, bus}, {24'h0, m_ram[0]});

        // Bus conflict: A wins over PC, B takes the A value.
        assert_reset();
        release_reset();
        load_a(8'h3C);
        stepc(PC_INC);
        stepc(PC_INC);
        stepc(PC_EN | A_EN | B_LOAD);
        check("conf_set", {31'h0, bus_conflict}, 32'h1);
        for (int i = 0; i < 3; i++) stepc(12'h000);
        check("conf_hold", {31'h0, bus_conflict}, 32'h1);
        load_a(8'h00);
        stepc(ADDER_EN);
        check("conf_b", {24'h0, bus}, 32'h3C);

        // Halt suppression; loader writes still land.
        assert_reset();
        release_reset();
        load_a(8'h77);
        stepc(HLT | A_LOAD);
        check("hlt_a",      {24'h0, a_out},  32'h00);
        check("hlt_halted", {31'h0, halted}, 32'h1);
        step(MEM_EN | A_LOAD, 1'b1, 4'h0, 8'hA5);
        check("hlt_a_hold", {24'h0, a_out}, 32'h00);
        assert_reset();
        release_reset();
        stepc(MEM_EN);
        check("hlt_write", {24'h0, bus}, 32'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
